issue_ctrl: RTL and testbench

- Single-issue scheduler between instruction fetch and the execute stage.
- Holds one fetched instruction in an instruction register (IR) and feeds it to the combinational decoder.
- Checks decoded rs1/rs2/rd against a register scoreboard, then issues to execute with a valid/ready handshake.
- Tracks outstanding register writes until writeback; handles flush drain and illegal-instruction trap.

---
 rtl/issue_ctrl_pkg.sv | 20 ++
 rtl/issue_scoreboard.sv | 65 ++++++
 rtl/issue_ctrl.sv | 94 +++++++++
 tb/tb_issue_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared widths, FSM encodings and helpers for the single-issue controller.
package issue_ctrl_pkg;

    localparam int RF_RANGE   = 4;   // msb index of a register-file address
    localparam int DATA_RANGE = 31;  // msb index of an instruction word
    localparam int RF_DEPTH   = 32;

    typedef enum logic [1:0] {
        ISSUE_ST_RUN   = 2'd0,
        ISSUE_ST_DRAIN = 2'd1,
        ISSUE_ST_TRAP  = 2'd2
    } issue_state_t;

    // One-hot select of a register; x0 never maps to a bit.
    function automatic logic [RF_DEPTH-1:0] reg_mask(input logic [RF_RANGE:0] addr);
        reg_mask       = '0;
        reg_mask[addr] = (addr != '0);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy bits and outstanding-write counter with RAW/WAW/cap hazard.
// Build option ISSUE_WB_BYPASS_EN lets the hazard check see this cycle's writeback.
module issue_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RF_RANGE:0]     rs1_addr,
    input  logic [RF_RANGE:0]     rs2_addr,
    input  logic [RF_RANGE:0]     waddr,
    input  logic                  reg_wen,
    input  logic                  issue,
    input  logic                  wb_valid,
    input  logic [RF_RANGE:0]     wb_addr,
    output logic [RF_DEPTH-1:0]   busy_vec,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  hazard,
    output logic                  pending_after_wb
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    logic                 wb_clr;
    logic                 do_set;
    logic [RF_DEPTH-1:0]  set_mask;
    logic [RF_DEPTH-1:0]  clr_mask;
    logic [RF_DEPTH-1:0]  busy_chk;
    logic [CNT_WIDTH-1:0] cnt_after_wb;
    logic [CNT_WIDTH-1:0] cnt_chk;

    always_comb begin
        wb_clr       = wb_valid && (wb_addr != '0) && busy_vec[wb_addr];
        clr_mask     = wb_clr ? reg_mask(wb_addr) : '0;
        do_set       = issue && reg_wen && (waddr != '0);
        set_mask     = do_set ? reg_mask(waddr) : '0;
        cnt_after_wb = outstanding - CNT_WIDTH'(wb_clr);
`ifdef ISSUE_WB_BYPASS_EN
        busy_chk     = busy_vec & ~clr_mask;
        cnt_chk      = cnt_after_wb;
`else
        busy_chk     = busy_vec;
        cnt_chk      = outstanding;
`endif
        // rs1/rs2 are checked for every format, used or not
        hazard = ((rs1_addr != '0) && busy_chk[rs1_addr])
              || ((rs2_addr != '0) && busy_chk[rs2_addr])
              || (reg_wen && (waddr != '0) && busy_chk[waddr])
              || (reg_wen && (cnt_chk == CNT_MAX));
        pending_after_wb = (cnt_after_wb != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec    <= '0;
            outstanding <= '0;
        end else begin
            busy_vec    <= (busy_vec | set_mask) & ~clr_mask;
            outstanding <= outstanding + CNT_WIDTH'(do_set) - CNT_WIDTH'(wb_clr);
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Single-issue scheduler: instruction register, execute handshake and flush/trap FSM.
// Optional build macro ISSUE_WB_BYPASS_EN (see issue_scoreboard).
//
//   state          | meaning
//   ISSUE_ST_RUN   | normal fetch/issue
//   ISSUE_ST_DRAIN | after flush, waiting for outstanding writes to retire
//   ISSUE_ST_TRAP  | illegal instruction issued, held until flush
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [DATA_RANGE:0]   if_instr,
    output logic                  if_ready,
    output logic [DATA_RANGE:0]   ir_instr,
    input  logic [RF_RANGE:0]     dec_rs1_addr,
    input  logic [RF_RANGE:0]     dec_rs2_addr,
    input  logic [RF_RANGE:0]     dec_waddr,
    input  logic                  dec_reg_wen,
    input  logic                  dec_ill_instr,
    output logic                  ex_valid,
    output logic [DATA_RANGE:0]   ex_instr,
    output logic                  ex_ill,
    input  logic                  ex_ready,
    input  logic                  wb_valid,
    input  logic [RF_RANGE:0]     wb_addr,
    input  logic                  flush,
    output logic [RF_DEPTH-1:0]   busy_vec,
    output logic [CNT_WIDTH-1:0]  outstanding
);

    issue_state_t state;
    logic         ir_valid;
    logic         hazard;
    logic         pending_after_wb;
    logic         fire;
    logic         load;

    // ex_valid is independent of ex_ready so the request stays stable under backpressure
    assign ex_valid = (state == ISSUE_ST_RUN) && ir_valid && !hazard && !flush;
    assign fire     = ex_valid && ex_ready;
    assign if_ready = (state == ISSUE_ST_RUN) && !flush && (!ir_valid || fire);
    assign load     = if_valid && if_ready;
    assign ex_instr = ir_instr;
    assign ex_ill   = ex_valid && dec_ill_instr;

    issue_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .rs1_addr         (dec_rs1_addr),
        .rs2_addr         (dec_rs2_addr),
        .waddr            (dec_waddr),
        .reg_wen          (dec_reg_wen),
        .issue            (fire && !dec_ill_instr),
        .wb_valid         (wb_valid),
        .wb_addr          (wb_addr),
        .busy_vec         (busy_vec),
        .outstanding      (outstanding),
        .hazard           (hazard),
        .pending_after_wb (pending_after_wb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ISSUE_ST_RUN;
            ir_valid <= 1'b0;
            ir_instr <= '0;
        end else if (flush) begin
            ir_valid <= 1'b0;
            state    <= pending_after_wb ? ISSUE_ST_DRAIN : ISSUE_ST_RUN;
        end else begin
            if (load) begin
                ir_valid <= 1'b1;
                ir_instr <= if_instr;
            end else if (fire) begin
                ir_valid <= 1'b0;
            end
            case (state)
                ISSUE_ST_RUN:   if (fire && dec_ill_instr) state <= ISSUE_ST_TRAP;
                ISSUE_ST_DRAIN: if (outstanding == '0) state <= ISSUE_ST_RUN;
                ISSUE_ST_TRAP:  state <= ISSUE_ST_TRAP;
                default:        state <= ISSUE_ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus randomized traffic, all checked
// against a set-of-busy-registers model of the issue rules.
module tb_issue_ctrl;

    localparam int MAXO = 4;
`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int M_RUN = 0, M_DRAIN = 1, M_TRAP = 2;
    localparam logic [6:0] OP_ALU = 7'h33, OP_IMM = 7'h13, OP_ST = 7'h23, OP_ILL = 7'h7F;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_valid = 1'b0, ex_ready = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic [31:0] if_instr = '0;
    logic [4:0]  wb_addr = '0;
    logic        if_ready, ex_valid, ex_ill, dec_reg_wen, dec_ill_instr;
    logic [31:0] ir_instr, ex_instr, busy_vec;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_waddr;
    logic [2:0]  outstanding;

    int n_vec = 0, n_err = 0;

    // reference model state
    bit [31:0]   m_busy;
    logic [31:0] m_ir;
    bit          m_irv, m_fire, m_wb_hit, m_wen, m_ill;
    logic [4:0]  m_rd;
    int          m_mode;
    bit          e_ex_valid, e_if_ready;
    logic [69:0] e_vec, obs;

    always #5 clk = ~clk;

    // external decoder
    assign dec_rs1_addr  = ir_instr[19:15];
    assign dec_rs2_addr  = ir_instr[24:20];
    assign dec_waddr     = ir_instr[11:7];
    assign dec_reg_wen   = (ir_instr[6:0] == OP_ALU) || (ir_instr[6:0] == OP_IMM);
    assign dec_ill_instr = (ir_instr[6:0] == OP_ILL);

    assign obs = {ex_valid, if_ready, ex_valid & ex_ill, ex_valid ? ex_instr : 32'h0, busy_vec, outstanding};

    issue_ctrl #(.MAX_OUTSTANDING(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .ir_instr(ir_instr), .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_waddr(dec_waddr), .dec_reg_wen(dec_reg_wen), .dec_ill_instr(dec_ill_instr),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_ill(ex_ill), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush), .busy_vec(busy_vec),
        .outstanding(outstanding)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        mk = {7'h0, 5'(rs2), 5'(rs1), 3'h0, 5'(rd), op};
    endfunction

    task automatic model_reset();
        m_busy = '0; m_ir = '0; m_irv = 1'b0; m_mode = M_RUN;
    endtask

    task automatic model_eval();
        logic [4:0] r1, r2;
        bit [31:0]  view;
        bit         haz;
        r1       = m_ir[19:15];
        r2       = m_ir[24:20];
        m_rd     = m_ir[11:7];
        m_wen    = (m_ir[6:0] == OP_ALU) || (m_ir[6:0] == OP_IMM);
        m_ill    = (m_ir[6:0] == OP_ILL);
        m_wb_hit = wb_valid && (wb_addr != 0) && m_busy[wb_addr];
        view     = m_busy;
        if (BYP && m_wb_hit) view[wb_addr] = 1'b0;
        haz = (r1 != 0 && view[r1]) || (r2 != 0 && view[r2])
           || (m_wen && m_rd != 0 && view[m_rd]) || (m_wen && $countones(view) >= MAXO);
        e_ex_valid = (m_mode == M_RUN) && m_irv && !haz && !flush;
        m_fire     = e_ex_valid && ex_ready;
        e_if_ready = (m_mode == M_RUN) && !flush && (!m_irv || m_fire);
        e_vec = {e_ex_valid, e_if_ready, e_ex_valid & m_ill, e_ex_valid ? m_ir : 32'h0,
                 m_busy, 3'($countones(m_busy))};
    endtask

    task automatic model_commit();
        int cnt_before;
        model_eval();
        cnt_before = $countones(m_busy);
        if (m_wb_hit) m_busy[wb_addr] = 1'b0;
        if (m_fire && m_wen && !m_ill && m_rd != 0) m_busy[m_rd] = 1'b1;
        if (flush) begin
            m_irv  = 1'b0;
            m_mode = ($countones(m_busy) != 0) ? M_DRAIN : M_RUN;
        end else if (m_mode == M_RUN) begin
            if (if_valid && e_if_ready) begin
                m_ir  = if_instr;
                m_irv = 1'b1;
            end else if (m_fire) begin
                m_irv = 1'b0;
            end
            if (m_fire && m_ill) m_mode = M_TRAP;
        end else if (m_mode == M_DRAIN && cnt_before == 0) begin
            m_mode = M_RUN;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; if_valid = 0; ex_ready = 0; wb_valid = 0; wb_addr = 0; flush = 0; if_instr = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_vec++; if (if_ready !== 1'b1 || ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_hs if_ready=%b ex_valid=%b exp 1/0", if_ready, ex_valid); end
        n_vec++; if (busy_vec !== 32'h0 || outstanding !== 3'd0 || ir_instr !== 32'h0) begin n_err++; $display("FAIL reset_regs busy=%h out=%0d ir=%h exp 0/0/0", busy_vec, outstanding, ir_instr); end
        rst = 1'b0;
        model_reset();
        settle();
        n_vec++; if (obs !== e_vec) begin n_err++; $display("FAIL reset_model got %h exp %h", obs, e_vec); end
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        ex_ready = 1; if_valid = 1; if_instr = mk(OP_ALU, 5, 1, 2);
        settle(); tick();
        if_instr = mk(OP_ALU, 6, 5, 1);
        settle();
        n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL raw_add_issue ex_valid=%b exp 1", ex_valid); end
        tick();
        if_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_vec++; if (ex_valid !== 1'b0 || busy_vec[5] !== 1'b1) begin n_err++; $display("FAIL raw_stall ex_valid=%b busy5=%b exp 0/1", ex_valid, busy_vec[5]); end
            n_vec++; if (obs !== e_vec) begin n_err++; $display("FAIL raw_model got %h exp %h", obs, e_vec); end
            tick();
        end
        wb_valid = 1; wb_addr = 5;
        settle();
        n_vec++; if (ex_valid !== BYP) begin n_err++; $display("FAIL raw_wb_cycle ex_valid=%b exp %b", ex_valid, BYP); end
        tick();
        wb_valid = 0;
        settle();
        n_vec++; if (busy_vec[5] !== 1'b0 || ex_valid !== !BYP) begin n_err++; $display("FAIL raw_after_wb busy5=%b ex_valid=%b exp 0/%b", busy_vec[5], ex_valid, !BYP); end
        n_vec++; if (obs !== e_vec) begin n_err++; $display("FAIL raw_model2 got %h exp %h", obs, e_vec); end
        tick();
    endtask

    task automatic test_cap();
        do_reset();
        ex_ready = 1; if_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            if_instr = mk(OP_ALU, (i == 5) ? 7 : i, 0, 0);
            settle();
            n_vec++; if (obs !== e_vec) begin n_err++; $display("FAIL cap_fill got %h exp %h", obs, e_vec); end
            tick();
        end
        if_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_vec++; if (outstanding !== 3'd4 || ex_valid !== 1'b0) begin n_err++; $display("FAIL cap_stall out=%0d ex_valid=%b exp 4/0", outstanding, ex_valid); end
            tick();
        end
        wb_valid = 1; wb_addr = 2;
        settle();
        n_vec++; if (ex_valid !== BYP) begin n_err++; $display("FAIL cap_wb_cycle ex_valid=%b exp %b", ex_valid, BYP); end
        tick();
        wb_valid = 0;
        settle();
        n_vec++; if (outstanding !== 3'(BYP ? 4 : 3) || ex_valid !== !BYP) begin n_err++; $display("FAIL cap_after_wb out=%0d ex_valid=%b", outstanding, ex_valid); end
        tick();
        settle();
        n_vec++; if (outstanding !== 3'd4 || busy_vec !== 32'h0000_009A) begin n_err++; $display("FAIL cap_fifth out=%0d busy=%h exp 4/0000009a", outstanding, busy_vec); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] a3, a4;
        a3 = mk(OP_ALU, 3, 1, 2);
        a4 = mk(OP_ALU, 4, 1, 2);
        do_reset();
        ex_ready = 1; if_valid = 1; if_instr = a3;
        settle(); tick();
        ex_ready = 0; if_instr = a4;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_vec++; if (ex_valid !== 1'b1 || ex_instr !== a3 || if_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold ex_valid=%b instr=%h if_ready=%b exp 1/%h/0", ex_valid, ex_instr, if_ready, a3); end
            tick();
        end
        ex_ready = 1;
        settle();
        n_vec++; if (if_ready !== 1'b1 || ex_valid !== 1'b1) begin n_err++; $display("FAIL bp_release if_ready=%b ex_valid=%b exp 1/1", if_ready, ex_valid); end
        tick();
        if_valid = 0;
        settle();
        n_vec++; if (ex_valid !== 1'b1 || ex_instr !== a4 || busy_vec !== 32'h8) begin n_err++; $display("FAIL bp_reload ex_valid=%b instr=%h busy=%h exp 1/%h/8", ex_valid, ex_instr, busy_vec, a4); end
        tick();
    endtask

    task automatic test_flush_drain();
        do_reset();
        ex_ready = 1; if_valid = 1;
        if_instr = mk(OP_ALU, 1, 0, 0); settle(); tick();
        if_instr = mk(OP_ALU, 2, 0, 0); settle(); tick();
        if_instr = mk(OP_ALU, 4, 1, 0); settle(); tick();
        if_valid = 0;
        settle();
        n_vec++; if (outstanding !== 3'd2 || ex_valid !== 1'b0) begin n_err++; $display("FAIL fl_pre out=%0d ex_valid=%b exp 2/0", outstanding, ex_valid); end
        flush = 1;
        settle();
        n_vec++; if (if_ready !== 1'b0 || ex_valid !== 1'b0) begin n_err++; $display("FAIL fl_cycle if_ready=%b ex_valid=%b exp 0/0", if_ready, ex_valid); end
        tick();
        flush = 0; if_valid = 1; if_instr = mk(OP_ALU, 9, 0, 0);
        settle();
        n_vec++; if (if_ready !== 1'b0 || ex_valid !== 1'b0 || outstanding !== 3'd2) begin n_err++; $display("FAIL fl_drain if_ready=%b ex_valid=%b out=%0d exp 0/0/2", if_ready, ex_valid, outstanding); end
        tick();
        wb_valid = 1; wb_addr = 1; settle(); tick();
        wb_addr = 2;
        settle();
        n_vec++; if (obs !== e_vec) begin n_err++; $display("FAIL fl_model got %h exp %h", obs, e_vec); end
        tick();
        wb_valid = 0;
        settle();
        n_vec++; if (outstanding !== 3'd0 || if_ready !== 1'b0) begin n_err++; $display("FAIL fl_zero out=%0d if_ready=%b exp 0/0", outstanding, if_ready); end
        tick();
        if_valid = 0;
        settle();
        n_vec++; if (if_ready !== 1'b1 || ex_valid !== 1'b0) begin n_err++; $display("FAIL fl_run if_ready=%b ex_valid=%b exp 1/0", if_ready, ex_valid); end
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        ex_ready = 1; if_valid = 1;
        if_instr = mk(OP_ALU, 5, 0, 0); settle(); tick();
        if_instr = 32'h0000_007F; settle(); tick();
        if_valid = 0;
        settle();
        n_vec++; if (ex_valid !== 1'b1 || ex_ill !== 1'b1 || busy_vec !== 32'h20) begin n_err++; $display("FAIL ill_issue ex_valid=%b ex_ill=%b busy=%h exp 1/1/20", ex_valid, ex_ill, busy_vec); end
        tick();
        if_valid = 1; if_instr = mk(OP_ALU, 6, 0, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            n_vec++; if (if_ready !== 1'b0 || ex_valid !== 1'b0 || busy_vec !== 32'h20) begin n_err++; $display("FAIL ill_trap if_ready=%b ex_valid=%b busy=%h exp 0/0/20", if_ready, ex_valid, busy_vec); end
            tick();
        end
        flush = 1; settle(); tick();
        flush = 0; if_valid = 0;
        wb_valid = 1; wb_addr = 5; settle(); tick();
        wb_valid = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++; if (obs !== e_vec) begin n_err++; $display("FAIL ill_drain got %h exp %h", obs, e_vec); end
            tick();
        end
        settle();
        n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL ill_exit if_ready=%b exp 1", if_ready); end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        ex_ready = 1; if_valid = 1;
        if_instr = mk(OP_ALU, 0, 1, 2); settle(); tick();
        if_instr = mk(OP_ALU, 3, 0, 0);
        settle();
        n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL x0_issue ex_valid=%b exp 1", ex_valid); end
        tick();
        if_valid = 0;
        settle(); tick();
        settle();
        n_vec++; if (busy_vec !== 32'h8 || outstanding !== 3'd1) begin n_err++; $display("FAIL x0_no_busy busy=%h out=%0d exp 8/1", busy_vec, outstanding); end
        wb_valid = 1; wb_addr = 0; settle(); tick();
        wb_addr = 9; settle(); tick();
        wb_valid = 0;
        settle();
        n_vec++; if (busy_vec !== 32'h8 || outstanding !== 3'd1) begin n_err++; $display("FAIL x0_wb_ignored busy=%h out=%0d exp 8/1", busy_vec, outstanding); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ex_ready = 1; if_valid = 1;
        if_instr = mk(OP_ALU, 1, 0, 0); settle(); tick();
        if_instr = mk(OP_ALU, 2, 0, 0); settle(); tick();
        if_valid = 0; settle(); tick();
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy_vec !== 32'h0 || outstanding !== 3'd0 || ex_valid !== 1'b0 || if_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid busy=%h out=%0d ex_valid=%b if_ready=%b", busy_vec, outstanding, ex_valid, if_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wb_valid = 1; wb_addr = 1; settle(); tick();
        wb_addr = 2; settle(); tick();
        wb_valid = 0;
        settle();
        n_vec++; if (busy_vec !== 32'h0 || outstanding !== 3'd0) begin n_err++; $display("FAIL rst_wb_ignored busy=%h out=%0d exp 0/0", busy_vec, outstanding); end
        tick();
    endtask

    task automatic test_random();
        int k, start, idx;
        logic [6:0] op;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            k  = int'($urandom_range(0, 99));
            op = (k < 72) ? OP_ALU : (k < 88) ? OP_ST : (k < 96) ? OP_IMM : OP_ILL;
            if_valid = ($urandom_range(0, 99) < 60);
            if_instr = mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            ex_ready = ($urandom_range(0, 99) < 70);
            wb_valid = ($urandom_range(0, 99) < 35);
            wb_addr  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 80) begin
                start = int'($urandom_range(0, 31));
                for (int j = 0; j < 32; j++) begin
                    idx = (start + j) % 32;
                    if (m_busy[idx]) begin
                        wb_addr = 5'(idx);
                        break;
                    end
                end
            end
            flush = (m_mode == M_TRAP) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 2);
            settle();
            n_vec++; if (obs !== e_vec) begin n_err++; $display("FAIL rand cyc %0d got %h exp %h", c, obs, e_vec); end
            tick();
        end
        flush = 0; if_valid = 0; wb_valid = 0;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_cap();
        test_backpressure();
        test_flush_drain();
        test_illegal();
        test_x0();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog bench did not reach its summary");
        $fatal(1, "watchdog");
    end

endmodule
